// File: rtl/jk_exc_drv.sv
// jk_exc_drv: drives the J/K inputs of an external bank of W JK flip-flops
// (clocked by the same clk) so that the bank reaches a requested target.
// The bank is driven for one cycle and then checked. A mismatch leads to a
// re-drive, up to MAX_RETRY extra attempts. After that the block raises err.
//
// Ports:
//   clk        single clock, all state changes on posedge
//   reset      asynchronous, active-low reset
//   tgt        requested next value of the bank (W bits)
//   tgt_valid  tgt is valid this cycle
//   tgt_ready  high exactly while the FSM is IDLE
//   q_fb       current q outputs of the external bank (W bits)
//   j, k       registered J/K drive, one bit per flop
//   done       one-cycle pulse when the bank matched the target
//   err        retries exhausted; held until the next accept or reset
//
// Optional feature: define JK_TOGGLE_OPT_EN to drive every differing bit with
// j=k=1 (toggle) instead of the set/reset encoding.
module jk_exc_drv #(
  parameter int W         = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] tgt,
  input  logic         tgt_valid,
  output logic         tgt_ready,
  input  logic [W-1:0] q_fb,
  output logic [W-1:0] j,
  output logic [W-1:0] k,
  output logic         done,
  output logic         err
);

  localparam int CW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  tgt_r;
  logic [CW-1:0] retry;

  // One excitation network is shared. At accept, the target comes straight
  // from the input port. On a re-drive, the target comes from the captured copy.
  logic [W-1:0] src, exc_j, exc_k;
  logic         exc_zero;

  assign src = (state == IDLE) ? tgt : tgt_r;

  for (genvar i = 0; i < W; i++) begin : g_lane
`ifdef JK_TOGGLE_OPT_EN
    // Toggle mode: every differing bit flips.
    assign exc_j[i] = src[i] ^ q_fb[i];
    assign exc_k[i] = src[i] ^ q_fb[i];
`else
    // Set/reset mode: j and k are never both high.
    assign exc_j[i] = src[i] & ~q_fb[i];
    assign exc_k[i] = ~src[i] & q_fb[i];
`endif
  end

  assign exc_zero  = ~|(exc_j | exc_k);
  assign tgt_ready = (state == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      tgt_r <= '0;
      retry <= '0;
      j     <= '0;
      k     <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (tgt_valid) begin
            tgt_r <= tgt;
            err   <= 1'b0;
            retry <= '0;
            j     <= exc_j;
            k     <= exc_k;
            // If the bank already matches, skip the drive cycle.
            state <= exc_zero ? CHECK : DRIVE;
          end
        end
        DRIVE: begin
          // The bank has taken the drive on this edge. Drop j/k so the
          // pulse lasts exactly one cycle.
          j     <= '0;
          k     <= '0;
          state <= CHECK;
        end
        CHECK: begin
          if (q_fb == tgt_r) begin
            done  <= 1'b1;
            state <= IDLE;
          end else if (retry < CW'(MAX_RETRY)) begin
            retry <= retry + CW'(1);
            j     <= exc_j;
            k     <= exc_k;
            state <= DRIVE;
          end else begin
            err   <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          j     <= '0;
          k     <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_exc_drv.sv
// Scoreboard bench for jk_exc_drv (W=4, MAX_RETRY=2) with a behavioural JK bank.
// The stimulus pushes the expected terminal event for each accept:
// kind (done/err), the cycle of the event, and the bank value.
// The monitor pops an entry and checks it on each done pulse or rising err.
module tb_jk_exc_drv;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] tgt;
  logic       tgt_valid;
  logic       tgt_ready;
  logic [3:0] q_fb;
  logic [3:0] j, k;
  logic       done, err;

  jk_exc_drv #(.W(4), .MAX_RETRY(2)) dut (
    .clk(clk), .reset(reset), .tgt(tgt), .tgt_valid(tgt_valid),
    .tgt_ready(tgt_ready), .q_fb(q_fb), .j(j), .k(k), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External JK bank. load forces a value. stuck ignores j/k.
  logic       load_en = 1'b0;
  logic [3:0] load_val = 4'h0;
  logic       stuck = 1'b0;
  always @(posedge clk) begin
    if (load_en) q_fb <= load_val;
    else if (!stuck)
      for (int i = 0; i < 4; i++)
        case ({j[i], k[i]})
          2'b10: q_fb[i] <= 1'b1;
          2'b01: q_fb[i] <= 1'b0;
          2'b11: q_fb[i] <= ~q_fb[i];
          default: ;
        endcase
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       is_err;
    logic [3:0] q;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  // Monitor
  logic err_prev = 1'b0;
  always @(negedge clk) begin
    if (!reset) err_prev = 1'b0;
    else begin
      if (done || (err && !err_prev)) begin
        chk_int("done_err_excl", int'(done && err), 0);
        if (sb.size() == 0) begin
          chk_int("unexpected_event", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk_int("mon_kind", int'(err), int'(e.is_err));
          chk_int("mon_cyc", cyc, e.cyc);
          chk("mon_bank", q_fb, e.q);
        end
      end
      err_prev = err;
    end
  end

  task automatic load_bank(input logic [3:0] v);
    @(negedge clk);
    load_en = 1'b1; load_val = v;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Issue one target at this negedge. It is accepted on the next posedge.
  // The terminal event is expected lat cycles after the accept.
  task automatic issue(input logic [3:0] v, input logic is_err,
                       input logic [3:0] qexp, input int lat);
    exp_t e;
    tgt = v; tgt_valid = 1'b1;
    e.is_err = is_err; e.q = qexp; e.cyc = cyc + 1 + lat;
    sb.push_back(e);
    @(negedge clk);
    tgt_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    exp_t e;
    reset = 1'b0; tgt = 4'h0; tgt_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_j", j, 4'b0000);
    chk("rst_k", k, 4'b0000);
    chk("rst_flags", {done, err, tgt_ready, 1'b0}, 4'b0010);
    reset = 1'b1;

    // Single drive: 0000 -> 1010
    load_bank(4'b0000);
    issue(4'b1010, 1'b0, 4'b1010, 2);
    chk("t1_j", j, 4'b1010);
    chk("t1_k", k, 4'b0000);
    @(negedge clk);
    chk("t1_j_clear", j, 4'b0000);
    repeat (3) @(negedge clk);
    chk("t1_bank", q_fb, 4'b1010);
    chk("t1_err", {3'b0, err}, 4'b0000);

    // Already matching: no drive, done after one cycle
    load_bank(4'b0110);
    issue(4'b0110, 1'b0, 4'b0110, 1);
    chk("t2_jk", j | k, 4'b0000);
    @(negedge clk);
    chk("t2_jk2", j | k, 4'b0000);
    repeat (2) @(negedge clk);

    // Stuck bank: three drive pulses, then err at 6 cycles, no done
    stuck = 1'b1;
    load_bank(4'b0000);
    issue(4'b1111, 1'b1, 4'b0000, 6);
    pulses = 0;
    for (int n = 0; n < 8; n++) begin
      if (n > 0) @(negedge clk);
      if (j == 4'b1111 && k == 4'b0000) pulses++;
    end
    chk_int("t3_pulses", pulses, 3);
    chk("t3_err_held", {3'b0, err}, 4'b0001);
    stuck = 1'b0;

    // Back-to-back with tgt_valid held high
    load_bank(4'b0000);
    tgt = 4'b0011; tgt_valid = 1'b1;
    e.is_err = 1'b0; e.q = 4'b0011; e.cyc = cyc + 3; sb.push_back(e);
    e.is_err = 1'b0; e.q = 4'b1100; e.cyc = cyc + 6; sb.push_back(e);
    @(negedge clk);
    chk("t4_err_cleared", {3'b0, err}, 4'b0000);
    tgt = 4'b1100;  // ignored while busy
    repeat (3) @(negedge clk);
    tgt_valid = 1'b0;
    chk("t4_j2", j, 4'b1100);
    chk("t4_k2", k, 4'b0011);
    repeat (4) @(negedge clk);
    chk("t4_bank", q_fb, 4'b1100);

    // Excitation encoding depends on the build option
    load_bank(4'b0101);
    issue(4'b1001, 1'b0, 4'b1001, 2);
`ifdef JK_TOGGLE_OPT_EN
    chk("t6_j", j, 4'b1100);
    chk("t6_k", k, 4'b1100);
`else
    chk("t6_j", j, 4'b1000);
    chk("t6_k", k, 4'b0100);
`endif
    repeat (4) @(negedge clk);
    chk("t6_bank", q_fb, 4'b1001);

    // Reset during DRIVE: outputs clear immediately, no done/err follows
    load_bank(4'b0000);
    tgt = 4'b0101; tgt_valid = 1'b1;
    @(negedge clk);
    tgt_valid = 1'b0;
    chk("t5_j_drive", j, 4'b0101);
    #2 reset = 1'b0;
    #1;
    chk("t5_jk_async", j | k, 4'b0000);
    chk("t5_flags", {2'b0, done, err}, 4'b0000);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_ready", {3'b0, tgt_ready}, 4'b0001);
    repeat (4) @(negedge clk);
    chk("t5_bank", q_fb, 4'b0000);

    chk_int("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jk_exc_drv.md
JK_EXC_DRV -- requirements
Module: jk_exc_drv

Interface
REQ-001 Parameter W, default 4: width of the driven JK flip-flop bank.
REQ-002 Parameter MAX_RETRY, default 2: re-drive attempts allowed after the first drive before error.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 tgt  input  W  requested next value of the JK bank.
REQ-006 tgt_valid  input  1  tgt is valid this cycle.
REQ-007 tgt_ready  output  1  block can accept a target; high exactly when state is IDLE.
REQ-008 q_fb  input  W  current q outputs of the external JK bank, clocked by the same clk.
REQ-009 j  output  W  registered J drive, one bit per flop.
REQ-010 k  output  W  registered K drive, one bit per flop.
REQ-011 done  output  1  registered one-cycle pulse: bank matched the target.
REQ-012 err  output  1  registered flag: retries exhausted; held until the next accept or reset.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, DRIVE, CHECK.
REQ-014 Accept occurs on a posedge with state IDLE and tgt_valid=1; the block SHALL capture tgt into tgt_r, clear err and the retry count, and load j/k with excitation(tgt, q_fb).
REQ-015 Excitation without toggle mode: tgt=1,q=0 -> j=1,k=0; tgt=0,q=1 -> j=0,k=1; equal bits -> j=k=0; j&k is never 1.
REQ-016 If excitation is all-zero at accept (tgt==q_fb), the block SHALL go directly to CHECK; otherwise it SHALL go to DRIVE.
REQ-017 In DRIVE, the next posedge SHALL clear j and k to 0 and go to CHECK, so j/k are nonzero for exactly one cycle per drive.
REQ-018 In CHECK, on the next posedge: if q_fb==tgt_r, the block SHALL pulse done and go to IDLE.
REQ-019 On mismatch in CHECK with retry count < MAX_RETRY, the block SHALL increment the count, reload j/k with excitation(tgt_r, q_fb), and go to DRIVE.
REQ-020 On mismatch in CHECK with retry count == MAX_RETRY, the block SHALL set err, leave j=k=0, and go to IDLE with no done pulse.
REQ-021 Latency SHALL be: done high 2 cycles after the accept edge for a successful single drive, and 1 cycle after it when tgt==q_fb.
REQ-022 tgt_valid SHALL be ignored outside IDLE, and tgt changes after accept SHALL have no effect.
REQ-023 A new accept SHALL be possible in the same cycle done is high (back-to-back targets).
REQ-024 done and err SHALL never be high in the same cycle.
REQ-025 Retry count width SHALL be clog2(MAX_RETRY+1), minimum 1 bit, and SHALL never wrap.

Reset
REQ-026 On reset=0 the block SHALL immediately, without waiting for a clock edge, force state=IDLE, j=0, k=0, done=0, err=0, tgt_r=0, and retry count=0.
REQ-027 Reset asserted mid-DRIVE or mid-CHECK SHALL abandon the operation with no done or err pulse; tgt_ready SHALL be 1 in the first cycle after release.

Configuration
REQ-028 Macro JK_TOGGLE_OPT_EN, when defined, SHALL drive every differing bit with j=k=1 (toggle), and equal bits with j=k=0.
REQ-029 Without JK_TOGGLE_OPT_EN, REQ-015 set/reset encoding SHALL apply, and j&k SHALL be 0 for every bit.
REQ-030 The FSM, latency, and retry behaviour SHALL be identical with and without the macro.

Verification
REQ-031 W=4, bank q=0000, accept tgt=1010 -> j=1010,k=0000 for one cycle; done 2 cycles after accept; bank=1010; err=0.
REQ-032 q=0110, accept tgt=0110 -> j=k=0000 throughout; done 1 cycle after accept.
REQ-033 Bank model ignores j/k (stuck at 0000), tgt=1111, MAX_RETRY=2 -> three one-cycle drive pulses; err=1 at 6 cycles after accept; no done.
REQ-034 Back-to-back tgt=0011 then 1100 with tgt_valid held high -> second accept in the done cycle; both done pulses; final bank=1100.
REQ-035 Reset driven low during the DRIVE cycle -> j=k=0 with no clock edge; no done or err; tgt_ready=1 after release.
REQ-036 With JK_TOGGLE_OPT_EN, q=0101, tgt=1001 -> j=k=1100 for one cycle; bank=1001; done 2 cycles after accept.
